ipsxe_floating_point_lead_one_pipe_v1_0: RTL

- Parametrised, pipelined leading/trailing-one locator with valid tracking.
- Supports any operand width and a runtime scan direction.
- Returns the bit index of the first set bit, the zero count skipped before it, and an all-zero flag.
- Feeds normalisation shifters in the fixed-to-float, float add/sub and reciprocal datapaths. Replaces the fixed 32/64-bit combinational locators.

---
 rtl/ipsxe_floating_point_lead_one_pipe_v1_0.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/ipsxe_floating_point_lead_one_pipe_v1_0.sv
// ============================================================================
// ipsxe_floating_point_lead_one_pipe_v1_0
// Pipelined leading/trailing-one locator: bit index, zero count, all-zero flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ipsxe_floating_point_lead_one_pipe_v1_0 #(
  parameter int WIDTH       = 64,
  parameter int LOC_BITS    = 6,
  parameter int SEG_WIDTH   = 16,
  parameter int PIPE_STAGES = 2
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_aclken,
  input  logic                i_valid,
  input  logic                i_mode,
  input  logic [WIDTH-1:0]    i_data,
  output logic                o_valid,
  output logic [LOC_BITS-1:0] o_one_location,
  output logic [LOC_BITS:0]   o_lz_count,
  output logic                o_zero_judge
);

  localparam int NSEG     = (WIDTH + SEG_WIDTH - 1) / SEG_WIDTH;
  localparam int PAD_W    = NSEG * SEG_WIDTH;
  localparam int SEG_BITS = $clog2(SEG_WIDTH);

  // Index of the first set bit inside one segment; lsb=1 scans from bit 0 upward.
  function automatic logic [SEG_BITS-1:0] seg_locate(input logic [SEG_WIDTH-1:0] seg,
                                                     input logic lsb);
    logic [SEG_BITS-1:0] idx;
    idx = '0;
    if (!lsb) begin
      for (int j = 0; j < SEG_WIDTH; j++) begin
        if (seg[j]) idx = SEG_BITS'(j);
      end
    end else begin
      for (int j = SEG_WIDTH - 1; j >= 0; j--) begin
        if (seg[j]) idx = SEG_BITS'(j);
      end
    end
    return idx;
  endfunction

  // Stage 1: per-segment search on the zero-padded operand
  logic [PAD_W-1:0]                 s1_padded;
  logic [NSEG-1:0]                  s1_nz;
  logic [NSEG-1:0][SEG_BITS-1:0]    s1_idx;

  always_comb begin
    s1_padded = PAD_W'(i_data);
    s1_nz     = '0;
    s1_idx    = '0;
    for (int s = 0; s < NSEG; s++) begin
      s1_nz[s]  = |s1_padded[s*SEG_WIDTH +: SEG_WIDTH];
      s1_idx[s] = seg_locate(s1_padded[s*SEG_WIDTH +: SEG_WIDTH], i_mode);
    end
  end

  logic                             s2_valid;
  logic                             s2_mode;
  logic [NSEG-1:0]                  s2_nz;
  logic [NSEG-1:0][SEG_BITS-1:0]    s2_idx;

  generate
    if (PIPE_STAGES == 2) begin : g_two_stage
      logic                          valid1_q, valid1_d;
      logic                          mode1_q, mode1_d;
      logic [NSEG-1:0]               nz1_q, nz1_d;
      logic [NSEG-1:0][SEG_BITS-1:0] idx1_q, idx1_d;

      always_comb begin
        valid1_d = valid1_q;
        mode1_d  = mode1_q;
        nz1_d    = nz1_q;
        idx1_d   = idx1_q;
        if (i_aclken) begin
          valid1_d = i_valid;
          if (i_valid) begin
            mode1_d = i_mode;
            nz1_d   = s1_nz;
            idx1_d  = s1_idx;
          end
        end
      end

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          valid1_q <= 1'b0;
          mode1_q  <= 1'b0;
          nz1_q    <= '0;
          idx1_q   <= '0;
        end else begin
          valid1_q <= valid1_d;
          mode1_q  <= mode1_d;
          nz1_q    <= nz1_d;
          idx1_q   <= idx1_d;
        end
      end

      assign s2_valid = valid1_q;
      assign s2_mode  = mode1_q;
      assign s2_nz    = nz1_q;
      assign s2_idx   = idx1_q;
    end else begin : g_one_stage
      assign s2_valid = i_valid;
      assign s2_mode  = i_mode;
      assign s2_nz    = s1_nz;
      assign s2_idx   = s1_idx;
    end
  endgenerate

  // Stage 2: pick the winning segment; later loop hits override earlier ones
  logic                found;
  logic [LOC_BITS-1:0] sel_loc;
  logic [LOC_BITS:0]   sel_lz;

  always_comb begin
    found   = 1'b0;
    sel_loc = '0;
    if (!s2_mode) begin
      for (int s = 0; s < NSEG; s++) begin
        if (s2_nz[s]) begin
          found   = 1'b1;
          sel_loc = LOC_BITS'(s * SEG_WIDTH) + LOC_BITS'(s2_idx[s]);
        end
      end
    end else begin
      for (int s = NSEG - 1; s >= 0; s--) begin
        if (s2_nz[s]) begin
          found   = 1'b1;
          sel_loc = LOC_BITS'(s * SEG_WIDTH) + LOC_BITS'(s2_idx[s]);
        end
      end
    end
    if (!found)       sel_lz = (LOC_BITS+1)'(WIDTH);
    else if (s2_mode) sel_lz = {1'b0, sel_loc};
    else              sel_lz = (LOC_BITS+1)'(WIDTH - 1) - {1'b0, sel_loc};
  end

  logic                valid_q, valid_d;
  logic [LOC_BITS-1:0] loc_q, loc_d;
  logic [LOC_BITS:0]   lz_q, lz_d;
  logic                zero_q, zero_d;

  always_comb begin
    valid_d = valid_q;
    loc_d   = loc_q;
    lz_d    = lz_q;
    zero_d  = zero_q;
    if (i_aclken) begin
      valid_d = s2_valid;
      if (s2_valid) begin
        loc_d  = sel_loc;
        lz_d   = sel_lz;
        zero_d = ~found;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q <= 1'b0;
      loc_q   <= '0;
      lz_q    <= '0;
      zero_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      loc_q   <= loc_d;
      lz_q    <= lz_d;
      zero_q  <= zero_d;
    end
  end

  assign o_valid        = valid_q;
  assign o_one_location = loc_q;
  assign o_lz_count     = lz_q;
  assign o_zero_judge   = zero_q;

endmodule

`default_nettype wire
